seg7_scan_driver: RTL

//  Consumes ONES/TENS/HUNDREDS BCD digits from the binary-to-BCD converter.

---
 rtl/seg7_scan_driver_pkg.sv | 31 +++
 rtl/seg7_scan_driver_if.sv | 17 +
 rtl/seg7_scan_driver_decode.sv | 24 ++
 rtl/seg7_scan_driver.sv | 109 ++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and segment constants for the 3-digit scanned 7-segment driver.
// Segment bits are {g,f,e,d,c,b,a}, active-low.
package seg7_scan_driver_pkg;

  typedef enum logic [1:0] {
    S_ONES = 2'd0,
    S_TENS = 2'd1,
    S_HUND = 2'd2,
    S_BAD  = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
  } bcd3_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit load / display pin bundle between the BCD source and the scan driver.
interface seg7_scan_driver_if;
  logic       load;
  logic [7:0] ones;
  logic [7:0] tens;
  logic [7:0] hundreds;
  logic       blank_lz;
  logic [6:0] seg;
  logic [2:0] an;
  logic       pending;
  logic       frame_done;

  modport master (output load, ones, tens, hundreds, blank_lz,
                  input  seg, an, pending, frame_done);
  modport slave  (input  load, ones, tens, hundreds, blank_lz,
                  output seg, an, pending, frame_done);
endinterface

// File: rtl/seg7_scan_driver_decode.sv
// BCD nibble to active-low segment pattern; non-decimal nibbles show a dash.
module seg7_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG_DASH;
    case (i_nib)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// Double-buffered 3-digit common-anode scan driver: a loaded value is held
// pending and only swapped onto the display at a frame boundary.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  seg7_scan_driver_if.slave bus
);
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  scan_state_t   r_state, w_state_nxt;
  bcd3_t         r_pend, r_disp, w_new;
  logic          r_pending, r_frame_done;
  logic [6:0]    r_seg, w_dec;
  logic [2:0]    r_an, w_an;
  logic [3:0]    w_nib;
  logic          w_tick, w_bnd, w_blank;
  logic          w_unused_hi;

  assign w_tick      = (r_cnt == CW'(CLK_DIV - 1));
  assign w_bnd       = w_tick && (r_state == S_HUND);
  assign w_new       = {bus.hundreds[3:0], bus.tens[3:0], bus.ones[3:0]};
  assign w_unused_hi = &{bus.hundreds[7:4], bus.tens[7:4], bus.ones[7:4]};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_state <= S_ONES;
    end else begin
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ONES:  if (w_tick) w_state_nxt = S_TENS;
      S_TENS:  if (w_tick) w_state_nxt = S_HUND;
      S_HUND:  if (w_tick) w_state_nxt = S_ONES;
      default: w_state_nxt = S_ONES;
    endcase
  end

  // A load coinciding with the boundary bypasses the pending buffer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pend       <= '0;
      r_disp       <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_bnd;
      if (w_bnd) begin
        if (bus.load) begin
          r_pend    <= w_new;
          r_disp    <= w_new;
          r_pending <= 1'b0;
        end else if (r_pending) begin
          r_disp    <= r_pend;
          r_pending <= 1'b0;
        end
      end else if (bus.load) begin
        r_pend    <= w_new;
        r_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_nib   = r_disp.o;
    w_an    = 3'b110;
    w_blank = 1'b0;
    case (r_state)
      S_TENS: begin
        w_nib   = r_disp.t;
        w_an    = 3'b101;
        w_blank = bus.blank_lz && (r_disp.h == 4'd0) && (r_disp.t == 4'd0);
      end
      S_HUND: begin
        w_nib   = r_disp.h;
        w_an    = 3'b011;
        w_blank = bus.blank_lz && (r_disp.h == 4'd0);
      end
      default: ;
    endcase
  end

  seg7_decode u_dec (.i_nib(w_nib), .o_seg(w_dec));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_seg <= SEG_OFF;
      r_an  <= 3'b111;
    end else begin
      r_seg <= w_blank ? SEG_OFF : w_dec;
      r_an  <= w_an;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.pending    = r_pending;
  assign bus.frame_done = r_frame_done;
endmodule
